alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 16, width of the issued-operation counter.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have ports r0_req_valid and r1_req_valid, input, 1 each, meaning requester N presents an operation.
REQ-005 The block SHALL have ports r0_req_ready and r1_req_ready, output, 1 each, meaning the arbiter accepts requester N's operation this cycle.
REQ-006 The block SHALL have ports rN_funct3, input, 3, rN_funct7, input, 1, rN_rs1 and rN_rs2, input, 32, carrying requester N's operation.
REQ-007 The block SHALL have ports r0_rsp_valid and r1_rsp_valid, output, 1 each, meaning a result for requester N is held.
REQ-008 The block SHALL have ports r0_rsp_ready and r1_rsp_ready, input, 1 each, meaning requester N consumes the result.
REQ-009 The block SHALL have ports rsp_data, output, 32, shared result, and rsp_z, output, 1, shared zero flag.
REQ-010 The block SHALL have ports alu_funct3 (3), alu_funct7 (1), alu_rs1 (32) and alu_rs2 (32), all outputs, registered operands to the ALU.
REQ-011 The block SHALL have ports alu_rd, input, 32, registered ALU result, and alu_z, input, 1, combinational ALU zero flag.
REQ-012 The block SHALL have ports busy, output, 1, meaning state is not IDLE, and ops_issued, output, CNT_W, count of accepted operations.

Function
REQ-013 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-014 In IDLE, the arbiter SHALL assert rN_req_ready only for the grant winner, and only while that requester's req_valid is high; at most one ready SHALL be high per cycle.
REQ-015 Arbitration SHALL be round-robin: if both requesters are valid, grant goes to the one not granted last; if one is valid, it wins. The last-grant register SHALL update on every accept.
REQ-016 On accept (valid and ready at the same edge), the arbiter SHALL latch funct3, funct7, rs1 and rs2 into the alu_* registers, latch the requester id, increment ops_issued (wrapping modulo 2^CNT_W), and go to EXEC.
REQ-017 In EXEC, the alu_* registers SHALL hold steady; at the EXEC edge the arbiter SHALL capture alu_z into the rsp_z register, and the FSM SHALL go to RESP.
REQ-018 In RESP, rsp_data SHALL equal alu_rd (operands unchanged, so the ALU result is stable), rsp_z SHALL hold the captured value, and rN_rsp_valid SHALL be high for the latched id only.
REQ-019 The latency from the accept edge to rsp_valid high SHALL be 2 cycles, with rsp_valid visible in the cycle after the EXEC edge.
REQ-020 rsp_valid, rsp_data and rsp_z SHALL hold unchanged until the owning rN_rsp_ready is high; the non-owning rsp_ready SHALL be ignored.
REQ-021 On response handshake in RESP: if any req_valid is high in that cycle, the arbiter SHALL arbitrate and accept it in that same cycle and go to EXEC (back-to-back, one operation per 2 cycles); otherwise it SHALL go to IDLE.
REQ-022 req_ready SHALL be low in EXEC, and low in RESP unless the response handshake occurs in that cycle.
REQ-023 Request inputs SHALL be sampled only at the accept edge; later changes SHALL NOT affect an in-flight operation.
REQ-024 busy SHALL be high in EXEC and RESP.

Reset
REQ-025 While rst_n is low, asynchronously: state = IDLE, last-grant = r1 (so r0 wins the first tie), all rsp_valid = 0, all req_ready = 0, rsp_z = 0, alu_* registers = 0, ops_issued = 0, busy = 0.
REQ-026 Reset asserted mid-operation SHALL drop the in-flight operation; no response SHALL appear after release.

Verification
REQ-027 r0 ADD, rs1=5, rs2=7, funct7=0 -> r0_rsp_valid high 2 cycles after accept, rsp_data=12, rsp_z=0, ops_issued=1.
REQ-028 r0 and r1 both valid after reset, r0 SUB 9-9 and r1 XOR 0xF0^0x0F -> r0 served first with rsp_data=0 and rsp_z=1, then r1 with rsp_data=0xFF and rsp_z=0.
REQ-029 Both requesters held valid with rsp_ready tied high -> grants alternate r0, r1, r0, r1, one accept every 2 cycles, no IDLE cycles.
REQ-030 r1 OR result with r1_rsp_ready low for 5 cycles and r0_rsp_ready high -> r1_rsp_valid and rsp_data stable across all 5 cycles, no new accept, r0_rsp_valid stays 0.
REQ-031 rst_n pulsed low during EXEC -> outputs immediately at reset values, no rsp_valid after release, ops_issued=0.
REQ-032 Preload ops_issued near 2^CNT_W-1 (for example, via a short CNT_W) and issue 2 operations -> counter wraps to 0, then 1.

Source files
------------

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter
//  Purpose  : Two-requester round-robin front end for one shared registered
//             ALU. An accepted request is latched onto the ALU operand
//             registers. The zero flag is captured one cycle later. The
//             response is then held for the owning requester until that
//             requester consumes it. A new request can be accepted in the
//             same cycle as the response handshake, so back-to-back traffic
//             sustains one operation every two cycles.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n                 clock, asynchronous active-low reset
//    rN_req_valid/ready         request handshake, requester N (0/1)
//    rN_funct3/funct7/rs1/rs2   requester N operation
//    rN_rsp_valid/ready         response handshake, requester N
//    rsp_data, rsp_z            shared response result and zero flag
//    alu_funct3/funct7/rs1/rs2  registered operands driven to the ALU
//    alu_rd, alu_z              ALU registered result, combinational zero
//    busy                       high while an operation is in flight
//    ops_issued                 count of accepted operations (wraps)
// ============================================================================
module alu_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    // requester 0
    input  logic             r0_req_valid,
    output logic             r0_req_ready,
    input  logic [2:0]       r0_funct3,
    input  logic             r0_funct7,
    input  logic [31:0]      r0_rs1,
    input  logic [31:0]      r0_rs2,
    output logic             r0_rsp_valid,
    input  logic             r0_rsp_ready,
    // requester 1
    input  logic             r1_req_valid,
    output logic             r1_req_ready,
    input  logic [2:0]       r1_funct3,
    input  logic             r1_funct7,
    input  logic [31:0]      r1_rs1,
    input  logic [31:0]      r1_rs2,
    output logic             r1_rsp_valid,
    input  logic             r1_rsp_ready,
    // shared response
    output logic [31:0]      rsp_data,
    output logic             rsp_z,
    // ALU side
    output logic [2:0]       alu_funct3,
    output logic             alu_funct7,
    output logic [31:0]      alu_rs1,
    output logic [31:0]      alu_rs2,
    input  logic [31:0]      alu_rd,
    input  logic             alu_z,
    // status
    output logic             busy,
    output logic [CNT_W-1:0] ops_issued
);

    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_last_gnt;   // id of the most recently accepted requester
    logic               r_id;         // owner of the in-flight operation
    logic [2:0]         r_funct3;
    logic               r_funct7;
    logic [31:0]        r_rs1;
    logic [31:0]        r_rs2;
    logic               r_rsp_z;
    logic [CNT_W-1:0]   r_ops;

    logic               w_gnt;
    logic               w_rsp_hs;
    logic               w_open;
    logic               w_rdy0;
    logic               w_rdy1;
    logic               w_accept;

    // Round-robin: on a tie the requester not granted last wins; otherwise
    // the single valid requester wins.
    assign w_gnt    = (r0_req_valid && r1_req_valid) ? ~r_last_gnt : r1_req_valid;

    // Only the owner's rsp_ready completes the response.
    assign w_rsp_hs = (r_state == ST_RESP) && (r_id ? r1_rsp_ready : r0_rsp_ready);

    // Acceptance window: idle, or the cycle the held response is consumed.
    // rst_n is folded in so that no ready escapes while reset is asserted
    // and the state register is being forced.
    assign w_open   = rst_n && ((r_state == ST_IDLE) || w_rsp_hs);
    assign w_rdy0   = w_open && r0_req_valid && !w_gnt;
    assign w_rdy1   = w_open && r1_req_valid &&  w_gnt;
    assign w_accept = w_rdy0 || w_rdy1;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (w_rsp_hs) begin
                    w_state_nxt = w_accept ? ST_EXEC : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand, ownership, flag and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_gnt <= 1'b1;    // r0 wins the first tie
            r_id       <= 1'b0;
            r_funct3   <= 3'd0;
            r_funct7   <= 1'b0;
            r_rs1      <= 32'd0;
            r_rs2      <= 32'd0;
            r_rsp_z    <= 1'b0;
            r_ops      <= '0;
        end else begin
            if (w_accept) begin
                r_last_gnt <= w_gnt;
                r_id       <= w_gnt;
                r_funct3   <= w_gnt ? r1_funct3 : r0_funct3;
                r_funct7   <= w_gnt ? r1_funct7 : r0_funct7;
                r_rs1      <= w_gnt ? r1_rs1    : r0_rs1;
                r_rs2      <= w_gnt ? r1_rs2    : r0_rs2;
                r_ops      <= r_ops + C_CNT_ONE;
            end
            // Operands have been stable for the whole EXEC cycle, so the
            // combinational zero flag is valid at this edge.
            if (r_state == ST_EXEC) begin
                r_rsp_z <= alu_z;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign r0_req_ready = w_rdy0;
    assign r1_req_ready = w_rdy1;

    assign r0_rsp_valid = (r_state == ST_RESP) && !r_id;
    assign r1_rsp_valid = (r_state == ST_RESP) &&  r_id;

    // alu_rd stays constant in RESP because the operand registers only
    // change on an accept, which also ends RESP.
    assign rsp_data     = (r_state == ST_RESP) ? alu_rd : 32'd0;
    assign rsp_z        = r_rsp_z;

    assign alu_funct3   = r_funct3;
    assign alu_funct7   = r_funct7;
    assign alu_rs1      = r_rs1;
    assign alu_rs2      = r_rs2;

    assign busy         = (r_state != ST_IDLE);
    assign ops_issued   = r_ops;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_arbiter
//  Purpose  : Self-checking bench for alu_arbiter. A small registered ALU
//             model sits behind the arbiter. A second instance with a 2-bit
//             counter shares every input to exercise counter wrap.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        r0_req_valid = 1'b0, r1_req_valid = 1'b0;
    logic        r0_req_ready, r1_req_ready;
    logic [2:0]  r0_funct3 = '0, r1_funct3 = '0;
    logic        r0_funct7 = 1'b0, r1_funct7 = 1'b0;
    logic [31:0] r0_rs1 = '0, r0_rs2 = '0, r1_rs1 = '0, r1_rs2 = '0;
    logic        r0_rsp_valid, r1_rsp_valid;
    logic        r0_rsp_ready = 1'b0, r1_rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_z;
    logic [2:0]  alu_funct3;
    logic        alu_funct7;
    logic [31:0] alu_rs1, alu_rs2;
    logic [31:0] alu_rd = '0;
    logic        alu_z;
    logic        busy;
    logic [15:0] ops_issued;

    // second instance outputs (short counter)
    logic        s_r0_req_ready, s_r1_req_ready, s_r0_rsp_valid, s_r1_rsp_valid;
    logic [31:0] s_rsp_data, s_alu_rs1, s_alu_rs2;
    logic        s_rsp_z, s_alu_funct7, s_busy;
    logic [2:0]  s_alu_funct3;
    logic [1:0]  s_ops_issued;

    int n_checks = 0;
    int n_fail   = 0;
    int m_ops    = 0;

    always #5 clk = ~clk;

    // ---------------- ALU model (registered result, comb zero) ----------
    logic [31:0] w_alu_res;
    always_comb begin
        w_alu_res = 32'd0;
        case (alu_funct3)
            3'd0: w_alu_res = alu_funct7 ? (alu_rs1 - alu_rs2) : (alu_rs1 + alu_rs2);
            3'd1: w_alu_res = alu_rs1 << alu_rs2[4:0];
            3'd2: w_alu_res = {31'd0, $signed(alu_rs1) < $signed(alu_rs2)};
            3'd3: w_alu_res = {31'd0, alu_rs1 < alu_rs2};
            3'd4: w_alu_res = alu_rs1 ^ alu_rs2;
            3'd5: w_alu_res = alu_funct7 ? ($signed(alu_rs1) >>> alu_rs2[4:0])
                                         : (alu_rs1 >> alu_rs2[4:0]);
            3'd6: w_alu_res = alu_rs1 | alu_rs2;
            default: w_alu_res = alu_rs1 & alu_rs2;
        endcase
    end
    assign alu_z = (w_alu_res == 32'd0);
    always @(posedge clk) alu_rd <= w_alu_res;

    alu_arbiter #(.CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready),
        .r0_funct3(r0_funct3), .r0_funct7(r0_funct7), .r0_rs1(r0_rs1), .r0_rs2(r0_rs2),
        .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
        .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready),
        .r1_funct3(r1_funct3), .r1_funct7(r1_funct7), .r1_rs1(r1_rs1), .r1_rs2(r1_rs2),
        .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
        .rsp_data(rsp_data), .rsp_z(rsp_z),
        .alu_funct3(alu_funct3), .alu_funct7(alu_funct7), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
        .alu_rd(alu_rd), .alu_z(alu_z),
        .busy(busy), .ops_issued(ops_issued)
    );

    alu_arbiter #(.CNT_W(2)) u_dut_w (
        .clk(clk), .rst_n(rst_n),
        .r0_req_valid(r0_req_valid), .r0_req_ready(s_r0_req_ready),
        .r0_funct3(r0_funct3), .r0_funct7(r0_funct7), .r0_rs1(r0_rs1), .r0_rs2(r0_rs2),
        .r0_rsp_valid(s_r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
        .r1_req_valid(r1_req_valid), .r1_req_ready(s_r1_req_ready),
        .r1_funct3(r1_funct3), .r1_funct7(r1_funct7), .r1_rs1(r1_rs1), .r1_rs2(r1_rs2),
        .r1_rsp_valid(s_r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
        .rsp_data(s_rsp_data), .rsp_z(s_rsp_z),
        .alu_funct3(s_alu_funct3), .alu_funct7(s_alu_funct7), .alu_rs1(s_alu_rs1), .alu_rs2(s_alu_rs2),
        .alu_rd(alu_rd), .alu_z(alu_z),
        .busy(s_busy), .ops_issued(s_ops_issued)
    );

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_ops(input string name);
        chk({name, ".ops"},  {16'd0, ops_issued},   m_ops & 32'hFFFF);
        chk({name, ".ops2"}, {30'd0, s_ops_issued}, m_ops & 32'h3);
    endtask

    task automatic set_req(input bit id, input bit v, input logic [2:0] f3,
                           input logic f7, input logic [31:0] a, input logic [31:0] b);
        if (!id) begin
            r0_req_valid = v; r0_funct3 = f3; r0_funct7 = f7; r0_rs1 = a; r0_rs2 = b;
        end else begin
            r1_req_valid = v; r1_funct3 = f3; r1_funct7 = f7; r1_rs1 = a; r1_rs2 = b;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_ops = 0;
        chk("rst.busy",   {31'd0, busy}, 32'd0);
        chk("rst.rsp_v0", {31'd0, r0_rsp_valid}, 32'd0);
        chk("rst.rsp_v1", {31'd0, r1_rsp_valid}, 32'd0);
        chk("rst.req_r0", {31'd0, r0_req_ready}, 32'd0);
        chk("rst.req_r1", {31'd0, r1_req_ready}, 32'd0);
        chk("rst.rsp_z",  {31'd0, rsp_z}, 32'd0);
        chk("rst.alu_rs1", alu_rs1, 32'd0);
        chk("rst.alu_rs2", alu_rs2, 32'd0);
        chk("rst.alu_f3", {29'd0, alu_funct3}, 32'd0);
        chk_ops("rst");
        @(negedge clk);
        r0_req_valid = 1'b0;
        r1_req_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit          id;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_d;
        logic        exp_z;
    } vec_t;

    // One isolated operation from idle: accept, EXEC, RESP, consume.
    task automatic run_vec(input vec_t v, input int idx);
        string nm;
        nm = $sformatf("vec%0d", idx);
        @(negedge clk);
        set_req(v.id, 1'b1, v.f3, v.f7, v.a, v.b);
        #1;
        chk({nm, ".req_rdy_own"}, {31'd0, v.id ? r1_req_ready : r0_req_ready}, 32'd1);
        chk({nm, ".req_rdy_oth"}, {31'd0, v.id ? r0_req_ready : r1_req_ready}, 32'd0);
        @(negedge clk);
        m_ops++;
        set_req(v.id, 1'b0, 3'd7, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678);  // post-accept changes ignored
        #1;
        chk({nm, ".exec_busy"}, {31'd0, busy}, 32'd1);
        chk({nm, ".exec_rspv"}, {30'd0, r1_rsp_valid, r0_rsp_valid}, 32'd0);
        @(negedge clk);
        #1;
        chk({nm, ".rsp_v"}, {30'd0, r1_rsp_valid, r0_rsp_valid}, v.id ? 32'd2 : 32'd1);
        chk({nm, ".data"}, rsp_data, v.exp_d);
        chk({nm, ".z"}, {31'd0, rsp_z}, {31'd0, v.exp_z});
        chk_ops(nm);
        if (!v.id) r0_rsp_ready = 1'b1; else r1_rsp_ready = 1'b1;
        @(negedge clk);
        r0_rsp_ready = 1'b0;
        r1_rsp_ready = 1'b0;
        #1;
        chk({nm, ".idle"}, {31'd0, busy}, 32'd0);
    endtask

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // id, funct3, funct7, rs1, rs2, expected data, expected zero
        vecs[0] = '{1'b0, 3'd0, 1'b0, 32'd5,        32'd7,        32'd12,         1'b0};
        vecs[1] = '{1'b1, 3'd0, 1'b1, 32'd9,        32'd9,        32'd0,          1'b1};
        vecs[2] = '{1'b0, 3'd4, 1'b0, 32'hF0,       32'h0F,       32'hFF,         1'b0};
        vecs[3] = '{1'b1, 3'd6, 1'b0, 32'h1200,     32'h0034,     32'h1234,       1'b0};
        vecs[4] = '{1'b0, 3'd7, 1'b0, 32'hFF00,     32'h0FF0,     32'h0F00,       1'b0};
        vecs[5] = '{1'b1, 3'd1, 1'b0, 32'd1,        32'd4,        32'd16,         1'b0};
        vecs[6] = '{1'b0, 3'd3, 1'b0, 32'd1,        32'd3,        32'd1,          1'b0};
        vecs[7] = '{1'b0, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'd1,       32'd0,          1'b1};

        r0_req_valid = 1'b1;   // ready must stay low while reset is held
        do_reset();

        // ---- directed table; 2-bit counter wraps after the 4th op ----
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

        // ---- tie after reset: r0 SUB 9-9 first, then r1 XOR ----
        do_reset();
        @(negedge clk);
        set_req(1'b0, 1'b1, 3'd0, 1'b1, 32'd9, 32'd9);
        set_req(1'b1, 1'b1, 3'd4, 1'b0, 32'hF0, 32'h0F);
        #1;
        chk("tie.r0_rdy", {31'd0, r0_req_ready}, 32'd1);
        chk("tie.r1_rdy", {31'd0, r1_req_ready}, 32'd0);
        @(negedge clk);
        m_ops++;
        r0_req_valid = 1'b0;
        #1;
        chk("tie.exec_r1_rdy", {31'd0, r1_req_ready}, 32'd0);
        @(negedge clk);
        #1;
        chk("tie.r0_rsp_v", {30'd0, r1_rsp_valid, r0_rsp_valid}, 32'd1);
        chk("tie.r0_data", rsp_data, 32'd0);
        chk("tie.r0_z", {31'd0, rsp_z}, 32'd1);
        chk("tie.resp_r1_rdy_lo", {31'd0, r1_req_ready}, 32'd0);
        r0_rsp_ready = 1'b1;
        #1;
        chk("tie.hs_r1_rdy", {31'd0, r1_req_ready}, 32'd1);
        @(negedge clk);
        m_ops++;
        r0_rsp_ready = 1'b0;
        r1_req_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("tie.r1_rsp_v", {30'd0, r1_rsp_valid, r0_rsp_valid}, 32'd2);
        chk("tie.r1_data", rsp_data, 32'hFF);
        chk("tie.r1_z", {31'd0, rsp_z}, 32'd0);
        chk_ops("tie");
        r1_rsp_ready = 1'b1;
        @(negedge clk);
        r1_rsp_ready = 1'b0;

        // ---- back-to-back: both valid, both rsp_ready high ----
        do_reset();
        @(negedge clk);
        set_req(1'b0, 1'b1, 3'd0, 1'b0, 32'd1, 32'd2);
        set_req(1'b1, 1'b1, 3'd0, 1'b0, 32'd10, 32'd20);
        r0_rsp_ready = 1'b1;
        r1_rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 10; k++) begin
            bit even, g;
            int owner;
            even = (k % 2) == 0;
            g    = ((k / 2) % 2) == 1;
            chk($sformatf("b2b%0d.r0_rdy", k), {31'd0, r0_req_ready}, {31'd0, even && !g});
            chk($sformatf("b2b%0d.r1_rdy", k), {31'd0, r1_req_ready}, {31'd0, even &&  g});
            chk($sformatf("b2b%0d.busy", k), {31'd0, busy}, (k == 0) ? 32'd0 : 32'd1);
            if (even && k >= 2) begin
                owner = ((k / 2) - 1) % 2;
                chk($sformatf("b2b%0d.rsp_v", k), {30'd0, r1_rsp_valid, r0_rsp_valid},
                    (owner == 1) ? 32'd2 : 32'd1);
                chk($sformatf("b2b%0d.data", k), rsp_data, (owner == 1) ? 32'd30 : 32'd3);
            end
            if (even) m_ops++;
            @(negedge clk);
            #1;
        end
        r0_req_valid = 1'b0;
        r1_req_valid = 1'b0;
        @(negedge clk);
        r0_rsp_ready = 1'b0;
        r1_rsp_ready = 1'b0;
        #1;
        chk("b2b.drain_idle", {31'd0, busy}, 32'd0);
        chk_ops("b2b");

        // ---- r1 response stalled 5 cycles, r0 traffic must not intrude ----
        @(negedge clk);
        set_req(1'b1, 1'b1, 3'd6, 1'b0, 32'h1200, 32'h0034);
        @(negedge clk);
        m_ops++;
        r1_req_valid = 1'b0;
        @(negedge clk);
        set_req(1'b0, 1'b1, 3'd0, 1'b0, 32'd3, 32'd4);
        r0_rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("stall%0d.r1_rsp_v", k), {31'd0, r1_rsp_valid}, 32'd1);
            chk($sformatf("stall%0d.r0_rsp_v", k), {31'd0, r0_rsp_valid}, 32'd0);
            chk($sformatf("stall%0d.data", k), rsp_data, 32'h1234);
            chk($sformatf("stall%0d.r0_rdy", k), {31'd0, r0_req_ready}, 32'd0);
            chk_ops($sformatf("stall%0d", k));
            @(negedge clk);
        end
        r0_req_valid = 1'b0;
        r0_rsp_ready = 1'b0;
        r1_rsp_ready = 1'b1;
        @(negedge clk);
        r1_rsp_ready = 1'b0;
        #1;
        chk("stall.idle", {31'd0, busy}, 32'd0);

        // ---- reset pulsed during EXEC drops the operation ----
        @(negedge clk);
        set_req(1'b0, 1'b1, 3'd0, 1'b0, 32'd1, 32'd1);
        @(negedge clk);   // EXEC now; keep valid high through reset
        #1;
        chk("mid.exec_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        m_ops = 0;
        chk("mid.busy", {31'd0, busy}, 32'd0);
        chk("mid.req_rdy", {30'd0, r1_req_ready, r0_req_ready}, 32'd0);
        chk("mid.alu_rs1", alu_rs1, 32'd0);
        chk_ops("mid");
        @(negedge clk);
        r0_req_valid = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("post%0d.rsp_v", k), {30'd0, r1_rsp_valid, r0_rsp_valid}, 32'd0);
            chk($sformatf("post%0d.busy", k), {31'd0, busy}, 32'd0);
            chk_ops($sformatf("post%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
